// File: rtl/mdu_pipe.sv
// Multiply/divide unit for the E stage; owns HI/LO and runs mult/div for a fixed latency.
// Ports: clk, reset (async high), start/md_op/a/b issue, busy, hi, lo.
module mdu_pipe #(
  parameter int WIDTH    = 32,
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAXLAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
  localparam int CW     = $clog2(MAXLAT) + 1;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSV   = 3'd7
  } md_op_e;

  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] phi_q, phi_d;
  logic [WIDTH-1:0] plo_q, plo_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dz_q, dz_d;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   b_nz;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   rem;
  logic               ovf;
  logic               b_zero;

  assign busy = (cnt_q != '0);
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Full 2*WIDTH product; sign-extend operands for the signed form.
  always_comb begin
    if (md_op == OP_MULT)
      prod = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
    else
      prod = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  end

  // Divisor forced non-zero so the divider never sees 0; the
  // result is discarded by dz_q in that case anyway.
  assign b_zero = (b == '0);
  assign b_nz   = b_zero ? WIDTH'(1) : b;
  assign ovf    = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);

  always_comb begin
    if (md_op == OP_DIV) begin
      if (ovf) begin
        quo = a;
        rem = '0;
      end else begin
        quo = $signed(a) / $signed(b_nz);
        rem = $signed(a) % $signed(b_nz);
      end
    end else begin
      quo = a / b_nz;
      rem = a % b_nz;
    end
  end

  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    phi_d = phi_q;
    plo_d = plo_q;
    cnt_d = cnt_q;
    dz_d  = dz_q;
    if (busy) begin
      // start is ignored entirely while busy, including the final edge
      if (cnt_q == CW'(1)) begin
        cnt_d = '0;
        if (!dz_q) begin
          hi_d = phi_q;
          lo_d = plo_q;
        end
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end else if (start) begin
      case (md_op)
        OP_MULT, OP_MULTU: begin
          {phi_d, plo_d} = prod;
          dz_d  = 1'b0;
          cnt_d = CW'(MULT_LAT);
        end
        OP_DIV, OP_DIVU: begin
          phi_d = rem;
          plo_d = quo;
          dz_d  = b_zero;
          cnt_d = CW'(DIV_LAT);
        end
        OP_MTHI: hi_d = a;
        OP_MTLO: lo_d = a;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      phi_q <= '0;
      plo_q <= '0;
      cnt_q <= '0;
      dz_q  <= 1'b0;
    end else begin
      hi_q  <= hi_d;
      lo_q  <= lo_d;
      phi_q <= phi_d;
      plo_q <= plo_d;
      cnt_q <= cnt_d;
      dz_q  <= dz_d;
    end
  end

endmodule

// File: doc/mdu_pipe.md
Name: mdu_pipe

Overview:
- Multiply/divide unit for the E stage of the 5-stage pipeline; owns the HI/LO register pair.
- Accepts one operation per start pulse and runs multi-cycle mult/div for a parameterised latency, holding `busy` meanwhile.
- The stall unit stalls D when an MD-class instruction sits in D while `start` or `busy` is high.
- Successor to the single-cycle datapath: adds parameterised width and latency, plus signed/unsigned mult/div and mthi/mtlo.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_LAT, 5, cycles `busy` stays high after a mult/multu start; must be ≥1.
- DIV_LAT, 10, cycles `busy` stays high after a div/divu start; must be ≥1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state.
- start  input  1  issue strobe from E-stage decode; sampled at the rising edge.
- md_op  input  3  0=none, 1=mult, 2=multu, 3=div, 4=divu, 5=mthi, 6=mtlo; 7 reserved (treated as none).
- a  input  WIDTH  forwarded rs value (FE_RD1).
- b  input  WIDTH  forwarded rt value (FE_RD2).
- busy  output  1  high while a mult/div is in flight.
- hi  output  WIDTH  current HI register.
- lo  output  WIDTH  current LO register.

Behaviour:
- Reset (async, immediate):
  - `hi` = 0, `lo` = 0, `busy` = 0, counter = 0, pending result = 0.
  - Reset mid-operation aborts the operation; no HI/LO writeback occurs.
- Accept: an edge with `start` = 1, `busy` = 0 and a valid `md_op` accepts the operation.
  - While `busy` = 1, `start` is ignored entirely; the SU guarantees this does not happen.
  - `md_op` = 0 or 7 with `start` = 1 is a no-op.
- mthi / mtlo:
  - On the accepting edge, `hi` (or `lo`) ← `a`.
  - `busy` stays 0; the new value is visible on the output after that edge.
- Multiply (mult/multu), on the accepting edge:
  - Compute the 2·WIDTH product of `a` and `b`: signed for mult, unsigned for multu.
  - Latch it into the pending {HI, LO} register.
  - Load counter = MULT_LAT and set `busy` = 1.
- Divide (div/divu), on the accepting edge:
  - Pending LO = quotient, pending HI = remainder.
  - Load counter = DIV_LAT and set `busy` = 1.
  - Signed division truncates toward zero; the remainder takes the sign of the dividend.
  - Overflow case, signed −2^(WIDTH−1) / −1: LO = 0x8000_0000, HI = 0 (for WIDTH = 32).
  - `b` = 0: the operation still runs the full DIV_LAT cycles, but HI/LO are left unchanged at completion (a divide-by-zero flag is latched and suppresses writeback).
- Run:
  - Each subsequent edge with counter > 1 decrements the counter.
  - On the edge where counter = 1: counter → 0, `busy` → 0, and `hi`/`lo` ← pending (unless suppressed).
  - Net effect: `busy` is high for exactly LAT full cycles after the accepting edge; the new HI/LO is visible in the cycle `busy` first reads 0.
- Read path:
  - `hi`/`lo` are plain register outputs; there is no combinational bypass of pending results.
  - mfhi/mflo are handled in E by the SU stalling while `busy` or `start` is high.
- Operand capture:
  - `a`/`b` are sampled only on the accepting edge.
  - Changes during `busy` have no effect, so forwarding changes after issue are harmless.
- Back-to-back issue:
  - A `start` on the same edge where `busy` falls (counter = 1) is NOT accepted, because `busy` is still 1 at that edge.
  - The earliest next accept is the following edge.
- Width rules:
  - Counter width is clog2(max(MULT_LAT, DIV_LAT)) + 1.
  - All arithmetic is done at WIDTH or 2·WIDTH with no truncation before the HI/LO split.

Test Plan:
1. mult, `a` = 0xFFFF_FFFE (−2), `b` = 3:
   - `busy` is high for 5 cycles, then `hi` = 0xFFFF_FFFF, `lo` = 0xFFFF_FFFA.
   - multu with the same operands gives `hi` = 0x0000_0002, `lo` = 0xFFFF_FFFA.
2. div, `a` = −7 (0xFFFF_FFF9), `b` = 2:
   - After 10 busy cycles, `lo` = 0xFFFF_FFFD (−3), `hi` = 0xFFFF_FFFF (−1).
   - divu 7 / 2 gives `lo` = 3, `hi` = 1.
3. Preload HI = 0x1234 and LO = 0x5678 via mthi/mtlo (`busy` stays 0, values visible next cycle), then div by `b` = 0:
   - `busy` is high for 10 cycles.
   - Afterwards `hi` = 0x1234 and `lo` = 0x5678, unchanged.
4. Signed overflow, div 0x8000_0000 / 0xFFFF_FFFF:
   - `lo` = 0x8000_0000, `hi` = 0.
5. Issue mult (a = 3, b = 4):
   - Hold `start` = 1 with md_op = mtlo, a = 0xDEAD, during busy cycles 2–5 → ignored; `lo` = 12 at completion.
   - Second start on the first edge after `busy` falls → accepted.
6. Assert `reset` asynchronously mid-div (cycle 4 of 10):
   - `busy`, `hi` and `lo` go to 0 immediately, without waiting for a clock edge.
   - No writeback follows after `reset` deasserts.
